wavegen: RTL and testbench



---
 rtl/wavegen_pkg.sv | 11 +
 rtl/wavegen_shaper.sv | 39 +++
 rtl/wavegen.sv | 83 ++++++++
 tb/tb_wavegen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared types for the wavegen waveform generator.
package wavegen_pkg;

    typedef enum logic [1:0] {
        SAW_UP   = 2'd0,
        SAW_DN   = 2'd1,
        TRIANGLE = 2'd2,
        SQUARE   = 2'd3
    } mode_t;

endpackage

// File: rtl/wavegen_shaper.sv
// Combinational phase-to-sample shaper: sawtooth up/down, triangle, variable-duty square.
module wavegen_shaper
    import wavegen_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  mode_t                mode,
    input  logic [WIDTH-1:0]     duty,
    output logic [WIDTH-1:0]     sample
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] t;

    assign p = acc[ACC_WIDTH-1 -: WIDTH];
    // Triangle runs at twice the slope, folding on the accumulator MSB.
    assign t = acc[ACC_WIDTH-2 -: WIDTH];

    always_comb begin
        sample = '0;
        case (mode)
            SAW_UP:   sample = p;
            SAW_DN:   sample = ~p;
            TRIANGLE: sample = acc[ACC_WIDTH-1] ? ~t : t;
            SQUARE:   sample = (p < duty) ? '1 : '0;
            default:  sample = '0;
        endcase
    end

    generate
        if (ACC_WIDTH > WIDTH + 1) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^acc[ACC_WIDTH-WIDTH-2:0];
        end
    endgenerate

endmodule

// File: rtl/wavegen.sv
// Phase-accumulator waveform generator with shadowed config applied at period boundaries.
module wavegen
    import wavegen_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic [1:0]           mode,
    input  logic [ACC_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]     duty,
    output logic [WIDTH-1:0]     waveform,
    output logic                 wrap
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [ACC_WIDTH-1:0] step_a;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry_r;
    logic                 carry_next;
    logic                 cfg_load;
    mode_t                mode_a;
    logic [WIDTH-1:0]     duty_a;
    logic [WIDTH-1:0]     sample;

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, step_a};
        acc_next   = acc;
        carry_next = 1'b0;
        if (sync) begin
            acc_next   = '0;
            carry_next = 1'b1;
        end else if (en) begin
            acc_next   = sum[ACC_WIDTH-1:0];
            carry_next = sum[ACC_WIDTH];
        end
        // Inputs only take effect while idle or at a period boundary.
        cfg_load = sync | ~en | carry_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            carry_r <= 1'b0;
            mode_a  <= SAW_UP;
            step_a  <= '0;
            duty_a  <= '0;
        end else begin
            acc     <= acc_next;
            carry_r <= carry_next;
            if (cfg_load) begin
                mode_a <= mode_t'(mode);
                step_a <= step;
                duty_a <= duty;
            end
        end
    end

    wavegen_shaper #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_shaper (
        .acc    (acc),
        .mode   (mode_a),
        .duty   (duty_a),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waveform <= '0;
            wrap     <= 1'b0;
        end else begin
            waveform <= sample;
            wrap     <= carry_r;
        end
    end

endmodule

// File: tb/tb_wavegen.sv
// Self-checking bench for wavegen: shaper vector table, scenario sequences, random vs model.
module tb_wavegen;
    import wavegen_pkg::*;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ACC_WIDTH = 16;
    localparam int          MODULUS   = 65536;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        sync  = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [15:0] step  = 16'd0;
    logic [7:0]  duty  = 8'd0;
    logic [7:0]  waveform;
    logic        wrap;

    mode_t       sh_mode;
    logic [15:0] sh_acc;
    logic [7:0]  sh_duty;
    logic [7:0]  sh_sample;

    wavegen #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .mode     (mode),
        .step     (step),
        .duty     (duty),
        .waveform (waveform),
        .wrap     (wrap)
    );

    wavegen_shaper #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_shaper_ut (
        .acc    (sh_acc),
        .mode   (sh_mode),
        .duty   (sh_duty),
        .sample (sh_sample)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: phase as a plain integer, config as integers.
    int m_acc, m_carry, m_mode, m_step, m_duty, m_wave, m_wrap;

    typedef struct {
        int acc;
        int md;
        int duty;
        int exp;
    } sh_vec_t;

    sh_vec_t vecs[13];

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int shape(input int a, input int md, input int d);
        int p;
        p = a / 256;
        case (md)
            0:       return p;
            1:       return 255 - p;
            2:       return (a < 32768) ? a / 128 : 255 - (a - 32768) / 128;
            default: return (p < d) ? 255 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_carry = 0; m_mode = 0; m_step = 0; m_duty = 0; m_wave = 0; m_wrap = 0;
    endtask

    task automatic set_in(input bit e, input bit s, input int md, input int st, input int d);
        en   = e;
        sync = s;
        mode = 2'(md);
        step = 16'(st);
        duty = 8'(d);
    endtask

    // One clock edge: advance the model, then compare the DUT against it.
    task automatic tick();
        int  s;
        bit  load;
        @(posedge clk);
        m_wave = shape(m_acc, m_mode, m_duty);
        m_wrap = m_carry;
        if (sync) begin
            m_acc = 0; m_carry = 1; load = 1'b1;
        end else if (en) begin
            s       = m_acc + m_step;
            m_carry = (s >= MODULUS) ? 1 : 0;
            m_acc   = s % MODULUS;
            load    = (m_carry == 1);
        end else begin
            m_carry = 0; load = 1'b1;
        end
        if (load) begin
            m_mode = int'(mode); m_step = int'(step); m_duty = int'(duty);
        end
        #1;
        check("model_wave", int'(waveform), m_wave);
        check("model_wrap", int'(wrap), m_wrap);
    endtask

    initial begin
        int e, w, n, r;

        vecs[0]  = '{acc: 'h0000, md: 0, duty: 'h00, exp: 'h00};
        vecs[1]  = '{acc: 'h1234, md: 0, duty: 'h00, exp: 'h12};
        vecs[2]  = '{acc: 'h1234, md: 1, duty: 'h00, exp: 'hED};
        vecs[3]  = '{acc: 'hFFFF, md: 1, duty: 'h00, exp: 'h00};
        vecs[4]  = '{acc: 'h3F80, md: 2, duty: 'h00, exp: 'h7F};
        vecs[5]  = '{acc: 'h8000, md: 2, duty: 'h00, exp: 'hFF};
        vecs[6]  = '{acc: 'hFF80, md: 2, duty: 'h00, exp: 'h00};
        vecs[7]  = '{acc: 'h4000, md: 2, duty: 'h00, exp: 'h80};
        vecs[8]  = '{acc: 'h3FFF, md: 3, duty: 'h40, exp: 'hFF};
        vecs[9]  = '{acc: 'h4000, md: 3, duty: 'h40, exp: 'h00};
        vecs[10] = '{acc: 'h0000, md: 3, duty: 'h00, exp: 'h00};
        vecs[11] = '{acc: 'hFEFF, md: 3, duty: 'hFF, exp: 'hFF};
        vecs[12] = '{acc: 'hFF00, md: 3, duty: 'hFF, exp: 'h00};

        model_reset();
        #12;
        check("reset_wave", int'(waveform), 0);
        check("reset_wrap", int'(wrap), 0);

        foreach (vecs[i]) begin
            sh_acc  = 16'(vecs[i].acc);
            sh_mode = mode_t'(2'(vecs[i].md));
            sh_duty = 8'(vecs[i].duty);
            #1;
            check($sformatf("shaper_vec%0d", i), int'(sh_sample), vecs[i].exp);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Sawtooth up: 0..255, wrap on the 0 that follows 255.
        set_in(0, 0, 0, 256, 0);
        tick();
        set_in(1, 0, 0, 256, 0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            check("saw_up_wave", int'(waveform), (k - 1) % 256);
            check("saw_up_wrap", int'(wrap), (k == 257) ? 1 : 0);
        end

        // Mid-period change to SAW_DN/step 512 waits for the period boundary.
        set_in(1, 1, 0, 256, 0);
        tick();
        set_in(1, 0, 0, 256, 0);
        for (int j = 1; j <= 557; j++) begin
            tick();
            if (j <= 256) begin
                e = j - 1; w = (j == 1) ? 1 : 0;
            end else begin
                n = (j - 257) % 128;
                e = 255 - 2 * n; w = (n == 0) ? 1 : 0;
            end
            check("midchg_wave", int'(waveform), e);
            check("midchg_wrap", int'(wrap), w);
            if (j == 101) set_in(1, 0, 1, 512, 0);
        end

        // Sync at phase 180 with en=1.
        set_in(1, 1, 0, 256, 0);
        tick();
        set_in(1, 0, 0, 256, 0);
        for (int j = 1; j <= 181; j++) tick();
        set_in(1, 1, 0, 256, 0);
        tick();
        check("sync_en_s0_wave", int'(waveform), 181);
        check("sync_en_s0_wrap", int'(wrap), 0);
        set_in(1, 0, 0, 256, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("sync_en_wave", int'(waveform), j);
            check("sync_en_wrap", int'(wrap), (j == 0) ? 1 : 0);
        end

        // Sync while en=0: one wrap, then holds at 0.
        set_in(0, 1, 0, 256, 0);
        tick();
        check("sync_idle_s0_wave", int'(waveform), 3);
        set_in(0, 0, 0, 256, 0);
        for (int j = 0; j < 10; j++) begin
            tick();
            check("sync_idle_wave", int'(waveform), 0);
            check("sync_idle_wrap", int'(wrap), (j == 0) ? 1 : 0);
        end

        // Triangle.
        set_in(1, 1, 2, 256, 0);
        tick();
        set_in(1, 0, 2, 256, 0);
        for (int j = 1; j <= 300; j++) begin
            tick();
            n = (j - 1) % 256;
            e = (n < 128) ? 2 * n : 255 - 2 * (n - 128);
            check("tri_wave", int'(waveform), e);
            check("tri_wrap", int'(wrap), (n == 0) ? 1 : 0);
        end

        // Square duty 64, then duty 0.
        set_in(1, 1, 3, 256, 64);
        tick();
        set_in(1, 0, 3, 256, 64);
        for (int j = 1; j <= 300; j++) begin
            tick();
            n = (j - 1) % 256;
            check("sq64_wave", int'(waveform), (n < 64) ? 255 : 0);
        end
        set_in(1, 1, 3, 256, 0);
        tick();
        set_in(1, 0, 3, 256, 0);
        for (int j = 1; j <= 300; j++) begin
            tick();
            check("sq0_wave", int'(waveform), 0);
        end

        // Reset asserted mid-ramp clears immediately; idle restart stays at 0.
        set_in(1, 1, 0, 256, 0);
        tick();
        set_in(1, 0, 0, 256, 0);
        for (int j = 0; j < 50; j++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wave", int'(waveform), 0);
        check("rst_mid_wrap", int'(wrap), 0);
        model_reset();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("post_rst_wave", int'(waveform), 0);
            check("post_rst_wrap", int'(wrap), 0);
        end

        // Randomized stimulus against the model.
        for (int j = 0; j < 3000; j++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) n = 0;
            else if (r == 1) n = int'($urandom_range(1, 1023));
            else n = int'($urandom_range(0, 65535));
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                   int'($urandom_range(0, 3)), n, int'($urandom_range(0, 255)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
